// File: rtl/nibble_serial_adder_pkg.sv
// nibble_serial_adder_pkg: FSM state encodings and nibble width shared by the serial adder files
package nibble_serial_adder_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/nibble_serial_adder_adder.sv
// Adder_4bit: 4-bit ripple-carry adder; ports a, b (4b addends), ci (carry in), s (4b sum), co (carry out)
module Adder_4bit
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);
  logic [NIBBLE_W:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign co = c[NIBBLE_W];
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add (optionally subtract with SERIAL_SUB_EN) computed one nibble per cycle
// Ports: clk, rst_n (async active-low); in_valid/in_ready with a, b, cin (and sub when SERIAL_SUB_EN);
// out_valid/out_ready with registered result, cout, overflow.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);
  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = $clog2(NIBBLES);
  state_t             state, state_nx;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [WIDTH-1:0]   a_q, b_q, acc, b_op;
  logic               a_msb, b_msb, c0;
  logic [NIBBLE_W-1:0] sum;
  logic               co, last, accept;
`ifdef SERIAL_SUB_EN
  assign b_op = sub ? ~b : b;
  assign c0   = sub | cin;
`else
  assign b_op = b;
  assign c0   = cin;
`endif
  assign accept    = (state == IDLE) && in_valid;
  assign last      = idx == IDX_W'(NIBBLES - 1);
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  // Operands shift right each pass so the adder always sees the current nibble in the low bits
  Adder_4bit u_add (
    .a  (a_q[NIBBLE_W-1:0]),
    .b  (b_q[NIBBLE_W-1:0]),
    .ci (carry),
    .s  (sum),
    .co (co)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = in_valid ? RUN : IDLE;
      RUN:     state_nx = last ? DONE : RUN;
      DONE:    state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // Sums collect in acc so the previous result stays visible until the final pass
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx      <= '0;
      carry    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      idx   <= '0;
      carry <= c0;
      a_q   <= a;
      b_q   <= b_op;
      a_msb <= a[WIDTH-1];
      b_msb <= b_op[WIDTH-1];
    end else if (state == RUN) begin
      idx   <= idx + 1'b1;
      carry <= co;
      a_q   <= {{NIBBLE_W{1'b0}}, a_q[WIDTH-1:NIBBLE_W]};
      b_q   <= {{NIBBLE_W{1'b0}}, b_q[WIDTH-1:NIBBLE_W]};
      acc   <= {sum, acc[WIDTH-1:NIBBLE_W]};
      if (last) begin
        result   <= {sum, acc[WIDTH-1:NIBBLE_W]};
        cout     <= co;
        overflow <= (a_msb == b_msb) && (sum[NIBBLE_W-1] != a_msb);
      end
    end
endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 Derived constant: NIBBLES = WIDTH/4, the number of adder passes per operation.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  operand transfer request.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  WIDTH  first operand.
REQ-008 b  input  WIDTH  second operand.
REQ-009 cin  input  1  carry-in for add.
REQ-010 sub  input  1  subtract select; present only when SERIAL_SUB_EN is defined.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 result  output  WIDTH  sum/difference, registered.
REQ-014 cout  output  1  carry out of bit WIDTH-1, registered.
REQ-015 overflow  output  1  signed (two's-complement) overflow, registered.

Function
REQ-016 The block SHALL compute a WIDTH-bit add by passing one nibble per cycle, LSB nibble first, through a single 4-bit ripple adder instance.
REQ-017 FSM states: IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-018 IDLE: in_valid=1 -> latch a, b-operand, initial carry, nibble index 0; go to RUN. in_valid=0 -> stay.
REQ-019 RUN: each cycle write the adder sum to result nibble[index], register the adder carry as the next carry-in, and increment the index.
REQ-020 RUN: after the pass with index NIBBLES-1, go to DONE; the final carry -> cout; overflow is computed -> overflow.
REQ-021 Latency: out_valid SHALL rise exactly NIBBLES cycles after the accepting edge.
REQ-022 overflow = (opA[MSB] == opB'[MSB]) and (result[MSB] != opA[MSB]), where opB' is the post-inversion b-operand.
REQ-023 DONE: result, cout and overflow held stable while out_ready=0; out_ready=1 -> IDLE on the next edge.
REQ-024 in_valid in RUN or DONE SHALL be ignored; no operand is accepted on the DONE->IDLE edge.
REQ-025 Index wrap: index resets to 0 on every accept; no wrap-around within an operation.
REQ-026 result/cout/overflow from the previous operation remain visible in IDLE until the next DONE update.

Reset
REQ-027 rst_n=0 SHALL force IDLE, index 0, carry 0, result 0, cout 0, overflow 0, out_valid 0 immediately and at any state, including mid-RUN; in_ready SHALL be 1 after release.
REQ-028 Any operation in flight at reset SHALL be discarded, with no partial result delivered.

Configuration
REQ-029 Macro SERIAL_SUB_EN: when defined, sub=1 at accept latches ~b as the b-operand with initial carry 1 (cin ignored), giving a-b; cout=1 means no borrow.
REQ-030 Without SERIAL_SUB_EN: the sub port SHALL be absent, b is latched unmodified, and the initial carry = cin.

Structure
REQ-031 A shared package/include SHALL hold the FSM state encodings (IDLE, RUN, DONE) and the nibble width constant 4.
REQ-032 The sole sub-module SHALL be the existing 4-bit ripple-carry adder (Adder_4bit), instantiated once; no other arithmetic is permitted in the datapath.

Verification (WIDTH=16)
REQ-033 a=0x1234, b=0x0FFF, cin=0 -> result 0x2233, cout 0, overflow 0; out_valid rises exactly 4 cycles after accept.
REQ-034 a=0xFFFF, b=0x0001, cin=0 -> result 0x0000, cout 1, overflow 0.
REQ-035 a=0x7FFF, b=0x0001, cin=0 -> result 0x8000, cout 0, overflow 1.
REQ-036 SERIAL_SUB_EN, sub=1, a=0x0005, b=0x0007 -> result 0xFFFE, cout 0, overflow 0; a=0x8000, b=0x0001 -> 0x7FFF, overflow 1.
REQ-037 Hold out_ready=0 for 3 cycles in DONE while pulsing in_valid -> result stays stable, in_ready stays 0, and no second operation starts.
REQ-038 Assert rst_n=0 during the 2nd RUN cycle -> all outputs 0 and out_valid 0 immediately; after release in_ready=1, and the next add completes correctly.
